// File: rtl/nvme_db_pkg.sv
// nvme_db_pkg: shared FSM encoding, BAR0 doorbell offset and source-index helpers
package nvme_db_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [31:0] DB_BASE_OFFSET = 32'h1000;
    localparam logic SRC_SQ = 1'b0;
    localparam logic SRC_CQ = 1'b1;

    function automatic int src_idx(input int q, input logic kind);
        return 2 * q + int'(kind);
    endfunction

    function automatic logic [31:0] db_offset(input logic [31:0] idx, input logic [3:0] stride);
        return DB_BASE_OFFSET + idx * (32'd4 << stride);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant gated by adv
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);
    logic [IW-1:0] c;

    always_comb begin
        c   = '0;
        idx = '0;
        vld = 1'b0;
        // Scan from farthest to nearest so the source closest to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr) + k) % N);
            if (req[c]) begin
                idx = c;
                vld = 1'b1;
            end
        end
        gnt = (adv && vld) ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/nvme_db_sched.sv
// nvme_db_sched: coalescing round-robin scheduler for NVMe SQ-tail/CQ-head doorbell writes
module nvme_db_sched
    import nvme_db_pkg::*;
#(
    parameter int NUM_QUEUES     = 4,
    parameter int PTR_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            user_clk,
    input  logic                            user_reset_n,
    input  logic                            user_lnk_up,
    input  logic [3:0]                      dstrd,
    input  logic [NUM_QUEUES-1:0]           sq_tail_wr,
    input  logic [NUM_QUEUES*PTR_WIDTH-1:0] sq_tail_val,
    input  logic [NUM_QUEUES-1:0]           cq_head_wr,
    input  logic [NUM_QUEUES*PTR_WIDTH-1:0] cq_head_val,
    output logic                            write_sqtdbl,
    output logic [63:0]                     sqt_addr,
    output logic                            write_cqhdbl,
    output logic [63:0]                     cqh_addr,
    input  logic                            write_sqtdbl_done,
    input  logic                            write_cqhdbl_done,
    output logic [2*NUM_QUEUES-1:0]         pending,
    output logic                            busy,
    output logic                            db_timeout
);
    localparam int NS = 2 * NUM_QUEUES;
    localparam int IW = $clog2(NS);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [1:0]           state_q, state_d;
    logic [NS-1:0]        pend_q, pend_d, wr, gnt;
    logic [PTR_WIDTH-1:0] val_q [NS];
    logic [PTR_WIDTH-1:0] val_d [NS];
    logic [PTR_WIDTH-1:0] wval [NS];
    logic [IW-1:0]        ptr_q, ptr_d, idx_q, idx_d, gidx;
    logic                 gvld, adv, done, tmo, repend;
    logic                 sq_req_q, sq_req_d, cq_req_q, cq_req_d, to_q, to_d;
    logic [63:0]          sqt_q, sqt_d, cqh_q, cqh_d, desc;
    logic [TW-1:0]        tmr_q, tmr_d;

    rr_arbiter #(.N(NS), .IW(IW)) u_arb (
        .req(pend_q), .ptr(ptr_q), .adv(adv), .gnt(gnt), .idx(gidx), .vld(gvld)
    );

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            wr[src_idx(q, SRC_SQ)]   = sq_tail_wr[q];
            wr[src_idx(q, SRC_CQ)]   = cq_head_wr[q];
            wval[src_idx(q, SRC_SQ)] = sq_tail_val[q*PTR_WIDTH +: PTR_WIDTH];
            wval[src_idx(q, SRC_CQ)] = cq_head_val[q*PTR_WIDTH +: PTR_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        sq_req_d = sq_req_q;
        cq_req_d = cq_req_q;
        sqt_d    = sqt_q;
        cqh_d    = cqh_q;
        tmr_d    = tmr_q + 1'b1;
        to_d     = to_q;
        repend   = 1'b0;
        adv      = (state_q == ST_IDLE) && user_lnk_up;
        done     = sq_req_q ? write_sqtdbl_done : write_cqhdbl_done;
        tmo      = tmr_q == TW'(TIMEOUT_CYCLES - 1);
        desc     = {db_offset(32'(gidx), dstrd), 32'(val_q[gidx])};
        if (adv && gvld) begin
            state_d  = ST_ISSUE;
            idx_d    = gidx;
            ptr_d    = (gidx == IW'(NS - 1)) ? '0 : gidx + 1'b1;
            sq_req_d = gidx[0] == SRC_SQ;
            cq_req_d = gidx[0] == SRC_CQ;
            sqt_d    = (gidx[0] == SRC_SQ) ? desc : '0;
            cqh_d    = (gidx[0] == SRC_CQ) ? desc : '0;
            tmr_d    = '0;
        end else if (state_q == ST_ISSUE && (done || !user_lnk_up || tmo)) begin
            // A done wins over a simultaneous link drop or timeout: the write already happened.
            state_d  = done ? ST_GAP : ST_IDLE;
            repend   = !done;
            to_d     = to_q | (!done && tmo);
            sq_req_d = 1'b0;
            cq_req_d = 1'b0;
            sqt_d    = '0;
            cqh_d    = '0;
        end else if (state_q == ST_GAP) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            pend_d[i] = wr[i] | (pend_q[i] & ~gnt[i]) | (repend && idx_q == IW'(i));
            val_d[i]  = wr[i] ? wval[i] : val_q[i];
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            val_q    <= '{default: '0};
            ptr_q    <= '0;
            idx_q    <= '0;
            sq_req_q <= 1'b0;
            cq_req_q <= 1'b0;
            sqt_q    <= '0;
            cqh_q    <= '0;
            tmr_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            val_q    <= val_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            sq_req_q <= sq_req_d;
            cq_req_q <= cq_req_d;
            sqt_q    <= sqt_d;
            cqh_q    <= cqh_d;
            tmr_q    <= tmr_d;
            to_q     <= to_d;
        end
    end

    // The writer samples its request in the done cycle, so mask it there to avoid a repeat.
    assign write_sqtdbl = sq_req_q & ~write_sqtdbl_done;
    assign write_cqhdbl = cq_req_q & ~write_cqhdbl_done;
    assign sqt_addr     = sqt_q;
    assign cqh_addr     = cqh_q;
    assign pending      = pend_q;
    assign busy         = state_q != ST_IDLE;
    assign db_timeout   = to_q;
endmodule

// File: doc/nvme_db_sched.md
# nvme_db_sched

Doorbell scheduler sitting between the NVMe queue managers and the PCIe doorbell writer. Collects SQ-tail and CQ-head pointer updates from `NUM_QUEUES` queue pairs and coalesces repeated updates per queue. Grants one doorbell at a time in round-robin order and drives the writer's `write_sqtdbl`/`write_cqhdbl` request/done handshake with the correct BAR0 register offset and pointer value.

## Interface

Clocking and reset (already decided): one clock, `user_clk`; reset `user_reset_n` is asynchronous, active-low.

Parameters:
- `NUM_QUEUES`, 4: number of SQ/CQ pairs; sources = 2*NUM_QUEUES.
- `PTR_WIDTH`, 16: queue pointer width.
- `TIMEOUT_CYCLES`, 1024: maximum wait for a done pulse.

Ports:
- `user_clk` in 1: clock.
- `user_reset_n` in 1: async active-low reset.
- `user_lnk_up` in 1: PCIe link up.
- `dstrd` in 4: CAP.DSTRD doorbell stride.
- `sq_tail_wr` in NUM_QUEUES: per-queue SQ tail update strobe.
- `sq_tail_val` in NUM_QUEUES*PTR_WIDTH: new tail values (queue q at `[q*PTR_WIDTH +: PTR_WIDTH]`).
- `cq_head_wr` in NUM_QUEUES: per-queue CQ head update strobe.
- `cq_head_val` in NUM_QUEUES*PTR_WIDTH: new head values.
- `write_sqtdbl` out 1: SQ doorbell request to the writer.
- `sqt_addr` out 64: SQ doorbell descriptor.
- `write_cqhdbl` out 1: CQ doorbell request to the writer.
- `cqh_addr` out 64: CQ doorbell descriptor.
- `write_sqtdbl_done` in 1: writer completion pulse for the SQ request.
- `write_cqhdbl_done` in 1: writer completion pulse for the CQ request.
- `pending` out 2*NUM_QUEUES: per-source pending flags; bit 2q = SQ q, bit 2q+1 = CQ q.
- `busy` out 1: state ≠ IDLE.
- `db_timeout` out 1: sticky flag, cleared only by reset.

## Operation

Source tracking:
- Each source i has a pending flag and a PTR_WIDTH value register.
- A strobe loads the value and sets the pending flag on the next edge.
- A strobe while the source is already pending overwrites the value, so only the latest pointer is ever written.

Descriptor format:
- `[63:32]` = byte offset from BAR0 = `0x1000 + i*(4 << dstrd)`, truncated to 32 bits.
- `[31:PTR_WIDTH]` = 0.
- `[PTR_WIDTH-1:0]` = pointer value.
- The output descriptor not in use is driven to 0.

Arbitration:
- Round-robin over the 2*NUM_QUEUES sources; the priority pointer resets to 0.
- After each grant, the pointer becomes (granted+1) mod 2*NUM_QUEUES.

FSM (reset state IDLE):
- **IDLE**: if `user_lnk_up` and any pending, grant a source.
  - On grant: latch index and value, clear its pending flag, register the request and descriptor, go to ISSUE.
- **ISSUE**: hold the request and descriptor stable.
  - On the matching done: go to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES-1: set `db_timeout`, re-pend the source, go to IDLE.
  - If `user_lnk_up` drops: re-pend the source, go to IDLE.
- **GAP**: one cycle, then IDLE.

Request masking:
- Externally, `write_sqtdbl = sq_req_q & ~write_sqtdbl_done`, and likewise for CQ.
- The writer samples its request in the same cycle its done pulse is high; masking prevents a duplicate doorbell.
- Only one of `write_sqtdbl`/`write_cqhdbl` is ever high.

Boundary cases:
- Strobe on the source being granted, same edge: the grant takes the old value; the new value is stored and pending stays 1.
- Re-pending (timeout or link drop): the retried value is kept unless a newer strobe has already overwritten it.
- Updates are accepted while the link is down; issuing stalls until the link returns.
- Done pulses arriving in IDLE or GAP are ignored.
- Asynchronous reset mid-ISSUE: all requests drop immediately and pending flags clear.

## Timing

- Reset values: all outputs 0, including `pending`, `busy` and `db_timeout`; all pending flags 0; arbiter pointer 0.
- Strobe at cycle T → pending at T+1 → request high at T+2, when the FSM is IDLE.
- Done at cycle D → request masked low in D → GAP at D+1 → IDLE at D+2 → earliest next request at D+3.
- Timeout counter: cleared on entry to ISSUE and increments each ISSUE cycle.

## Structure

- Package `nvme_db_pkg`:
  - FSM state encoding (IDLE/ISSUE/GAP).
  - `DB_BASE_OFFSET = 32'h1000`.
  - Source-index helper constants (SQ = even, CQ = odd).
- Sub-module `rr_arbiter`: parameterised width; inputs are request vector, pointer and advance; outputs are one-hot grant and encoded index. It is natural and reusable for other shared PCIe request paths.

## Test plan

- **Single SQ doorbell:** dstrd=0, `sq_tail_wr[1]` with value 0x0005, done returned 4 cycles after the request → `write_sqtdbl` high at T+2 with `sqt_addr = 0x00001008_00000005`; request low in the done cycle; exactly one doorbell issued.
- **Coalescing:** 3 strobes to CQ 2 (values 7, 8, 9) while a request from another source is outstanding → a single CQ doorbell, offset 0x1014, value 9.
- **Round-robin:** all 8 sources pending at once → issue order 0,1,…,7; then with source 0 re-pended, the next grant after 3 goes to 4, not 0.
- **Timeout:** no done returned → `db_timeout` high after TIMEOUT_CYCLES; source re-pended and retried with the same value; flag stays high.
- **Link drop and reset:** `user_lnk_up` low mid-ISSUE → request drops next cycle and the source is still pending; link restored → reissued. Asserting `user_reset_n`=0 mid-ISSUE → all outputs 0 asynchronously.
